vga_timing: RTL and testbench

// Generates 640x480@60Hz VGA raster timing from the 50 MHz system clock.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_mod_counter.sv | 24 ++
 rtl/vga_timing.sv | 123 ++++++++++++
 tb/tb_vga_timing.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz VGA timing constants and 3-bit rgb colours.
// Drawable blocks take their screen bounds from here.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL =
        VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef logic [2:0] rgb_t;

    localparam rgb_t COLOR_BLACK   = 3'b000;
    localparam rgb_t COLOR_BLUE    = 3'b001;
    localparam rgb_t COLOR_GREEN   = 3'b010;
    localparam rgb_t COLOR_CYAN    = 3'b011;
    localparam rgb_t COLOR_RED     = 3'b100;
    localparam rgb_t COLOR_MAGENTA = 3'b101;
    localparam rgb_t COLOR_YELLOW  = 3'b110;
    localparam rgb_t COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/vga_timing_mod_counter.sv
// Modulo-N up counter with enable, used for the pixel divider, col and row.
// Ports: clock, reset (sync, high), enable; count, wrap (count==MODULUS-1).
module mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = (count == WIDTH'(MODULUS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, col/row counters, registered syncs.
// Ports: clock, reset (sync, high); col, row, hsync, vsync, video_on,
// pixel_tick, vblank_start.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLOCK_DIV   = 2,
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       vblank_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap;
    logic             col_wrap;
    logic             row_wrap;
    logic [9:0]       col_next;
    logic [9:0]       row_next;
    logic             tick_next;
    logic             hs_next;
    logic             vs_next;
    logic             on_next;
    logic             vb_next;

    mod_counter #(
        .WIDTH   (DIV_W),
        .MODULUS (CLOCK_DIV)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .count  (div_cnt),
        .wrap   (div_wrap)
    );

    mod_counter #(
        .WIDTH   (10),
        .MODULUS (H_TOTAL)
    ) u_col (
        .clock  (clock),
        .reset  (reset),
        .enable (pixel_tick),
        .count  (col),
        .wrap   (col_wrap)
    );

    mod_counter #(
        .WIDTH   (10),
        .MODULUS (V_TOTAL)
    ) u_row (
        .clock  (clock),
        .reset  (reset),
        .enable (pixel_tick & col_wrap),
        .count  (row),
        .wrap   (row_wrap)
    );

    // Predict the counter values after this edge so the decoded outputs
    // land in the same cycle as the counts they describe.
    always_comb begin
        div_next = div_wrap ? '0 : div_cnt + DIV_W'(1);
        col_next = col;
        row_next = row;
        if (pixel_tick) begin
            col_next = col_wrap ? '0 : col + 10'd1;
            if (col_wrap) begin
                row_next = row_wrap ? '0 : row + 10'd1;
            end
        end
        tick_next = (div_next == DIV_W'(CLOCK_DIV - 1));
        hs_next   = (col_next >= 10'(HS_START)) &&
                    (col_next <= 10'(HS_END));
        vs_next   = (row_next >= 10'(VS_START)) &&
                    (row_next <= 10'(VS_END));
        on_next   = (col_next < 10'(H_VISIBLE)) &&
                    (row_next < 10'(V_VISIBLE));
        // Only the step out of the last visible line's last pixel fires.
        vb_next   = pixel_tick && col_wrap &&
                    (row == 10'(V_VISIBLE - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_tick   <= (CLOCK_DIV == 1);
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            video_on     <= 1'b1;
            vblank_start <= 1'b0;
        end else begin
            pixel_tick   <= tick_next;
            hsync        <= hs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync        <= vs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on     <= on_next;
            vblank_start <= vb_next;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size line timing plus reduced-size frames
// for frame, reset, CLOCK_DIV=1 and SYNC_ACTIVE=1 cases.
module tb_vga_timing;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    // std: default 640x480, CLOCK_DIV=2
    logic       rs0;
    logic [9:0] c0, w0;
    logic       hs0, vs0, on0, tk0, vb0;
    // s2: small 15x10 raster, CLOCK_DIV=2
    logic       rs1;
    logic [9:0] c1, w1;
    logic       hs1, vs1, on1, tk1, vb1;
    // s1: small raster, CLOCK_DIV=1
    logic       rs2;
    logic [9:0] c2, w2;
    logic       hs2, vs2, on2, tk2, vb2;
    // sp: small raster, CLOCK_DIV=2, active-high syncs
    logic       rs3;
    logic [9:0] c3, w3;
    logic       hs3, vs3, on3, tk3, vb3;

    vga_timing u_std (
        .clock(clock), .reset(rs0), .col(c0), .row(w0),
        .hsync(hs0), .vsync(vs0), .video_on(on0),
        .pixel_tick(tk0), .vblank_start(vb0)
    );

    vga_timing #(
        .CLOCK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3),
        .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2),
        .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) u_s2 (
        .clock(clock), .reset(rs1), .col(c1), .row(w1),
        .hsync(hs1), .vsync(vs1), .video_on(on1),
        .pixel_tick(tk1), .vblank_start(vb1)
    );

    vga_timing #(
        .CLOCK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3),
        .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2),
        .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) u_s1 (
        .clock(clock), .reset(rs2), .col(c2), .row(w2),
        .hsync(hs2), .vsync(vs2), .video_on(on2),
        .pixel_tick(tk2), .vblank_start(vb2)
    );

    vga_timing #(
        .CLOCK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3),
        .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2),
        .V_BACK(1), .SYNC_ACTIVE(1'b1)
    ) u_sp (
        .clock(clock), .reset(rs3), .col(c3), .row(w3),
        .hsync(hs3), .vsync(vs3), .video_on(on3),
        .pixel_tick(tk3), .vblank_start(vb3)
    );

    typedef struct {
        int n;
        int col;
        int row;
        bit hs;
        bit vs;
        bit von;
        bit tick;
    } vec_t;

    localparam int NT = 13;
    vec_t tbl[NT];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Small rasters: reset state expected for CLOCK_DIV=2, active-low.
    task automatic chk_s2_reset(input int n);
        chk($sformatf("s2 rst n=%0d col", n), 32'(c1), 0);
        chk($sformatf("s2 rst n=%0d row", n), 32'(w1), 0);
        chk($sformatf("s2 rst n=%0d hs", n), 32'(hs1), 1);
        chk($sformatf("s2 rst n=%0d vs", n), 32'(vs1), 1);
        chk($sformatf("s2 rst n=%0d von", n), 32'(on1), 1);
        chk($sformatf("s2 rst n=%0d tick", n), 32'(tk1), 0);
        chk($sformatf("s2 rst n=%0d vb", n), 32'(vb1), 0);
    endtask

    int std_hs_lo, std_on, std_vb;
    int s2_hs_lo, s2_vs_lo, s2_on, s2_vb;
    int s1_hs_lo, s1_vs_lo, s1_tick, s1_vb;
    int sp_hs_hi, sp_vs_hi, sp_vb;

    initial begin
        int ti;
        // {clocks after release, col, row, hsync, vsync, video_on, tick}
        tbl = '{
            '{0,    0,   0, 1, 1, 1, 0},
            '{1,    0,   0, 1, 1, 1, 1},
            '{2,    1,   0, 1, 1, 1, 0},
            '{4,    2,   0, 1, 1, 1, 0},
            '{1279, 639, 0, 1, 1, 1, 1},
            '{1280, 640, 0, 1, 1, 0, 0},
            '{1311, 655, 0, 1, 1, 0, 1},
            '{1312, 656, 0, 0, 1, 0, 0},
            '{1503, 751, 0, 0, 1, 0, 1},
            '{1504, 752, 0, 1, 1, 0, 0},
            '{1599, 799, 0, 1, 1, 0, 1},
            '{1600, 0,   1, 1, 1, 1, 0},
            '{1601, 0,   1, 1, 1, 1, 1}
        };
        ti = 0;
        {std_hs_lo, std_on, std_vb} = '0;
        {s2_hs_lo, s2_vs_lo, s2_on, s2_vb} = '0;
        {s1_hs_lo, s1_vs_lo, s1_tick, s1_vb} = '0;
        {sp_hs_hi, sp_vs_hi, sp_vb} = '0;

        {rs0, rs1, rs2, rs3} = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        {rs0, rs1, rs2, rs3} = 4'b0000;

        for (int n = 0; n <= 1601; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
            end

            while (ti < NT && tbl[ti].n == n) begin
                chk($sformatf("std n=%0d col", n), 32'(c0), tbl[ti].col);
                chk($sformatf("std n=%0d row", n), 32'(w0), tbl[ti].row);
                chk($sformatf("std n=%0d hs", n), 32'(hs0),
                    32'(tbl[ti].hs));
                chk($sformatf("std n=%0d vs", n), 32'(vs0),
                    32'(tbl[ti].vs));
                chk($sformatf("std n=%0d von", n), 32'(on0),
                    32'(tbl[ti].von));
                chk($sformatf("std n=%0d tick", n), 32'(tk0),
                    32'(tbl[ti].tick));
                ti++;
            end

            if (vb0) std_vb++;
            if (n < 1600) begin
                if (!hs0) std_hs_lo++;
                if (on0) std_on++;
            end
            if (n < 300) begin
                if (!hs1) s2_hs_lo++;
                if (!vs1) s2_vs_lo++;
                if (on1) s2_on++;
                if (vb1) s2_vb++;
                if (hs3) sp_hs_hi++;
                if (vs3) sp_vs_hi++;
                if (vb3) sp_vb++;
            end
            if (n < 150) begin
                if (!hs2) s1_hs_lo++;
                if (!vs2) s1_vs_lo++;
                if (tk2) s1_tick++;
                if (vb2) s1_vb++;
            end

            if (n == 0) begin
                chk_s2_reset(0);
                chk("s1 rst tick", 32'(tk2), 1);
                chk("s1 rst col", 32'(c2), 0);
                chk("sp rst hs", 32'(hs3), 0);
                chk("sp rst vs", 32'(vs3), 0);
                chk("sp rst vb", 32'(vb3), 0);
            end
            if (n == 14) chk("s1 n=14 col", 32'(c2), 14);
            if (n == 15) begin
                chk("s1 n=15 col", 32'(c2), 0);
                chk("s1 n=15 row", 32'(w2), 1);
            end
            if (n == 90) chk("s1 vblank at (0,6)", 32'(vb2), 1);
            if (n == 149) begin
                chk("s1 n=149 col", 32'(c2), 14);
                chk("s1 n=149 row", 32'(w2), 9);
            end
            if (n == 150) begin
                chk("s1 frame wrap col", 32'(c2), 0);
                chk("s1 frame wrap row", 32'(w2), 0);
            end
            if (n == 180) begin
                chk("s2 vblank at (0,6)", 32'(vb1), 1);
                chk("s2 vblank col", 32'(c1), 0);
                chk("s2 vblank row", 32'(w1), 6);
                chk("sp vblank at (0,6)", 32'(vb3), 1);
            end
            if (n == 181) chk("s2 vblank one clock", 32'(vb1), 0);
            if (n == 299) begin
                chk("s2 n=299 col", 32'(c1), 14);
                chk("s2 n=299 row", 32'(w1), 9);
            end
            if (n == 300) begin
                chk("s2 row wrap col", 32'(c1), 0);
                chk("s2 row wrap row", 32'(w1), 0);
            end

            // Reset mid-line inside both syncs, held for 10 more clocks.
            if (n == 562) begin
                chk("s2 pre-rst col", 32'(c1), 11);
                chk("s2 pre-rst row", 32'(w1), 8);
                chk("s2 pre-rst hs", 32'(hs1), 0);
                chk("s2 pre-rst vs", 32'(vs1), 0);
                rs1 = 1'b1;
            end
            if (n >= 563 && n <= 573) chk_s2_reset(n);
            if (n == 573) rs1 = 1'b0;
            if (n == 574) begin
                chk("s2 resume col", 32'(c1), 0);
                chk("s2 resume tick", 32'(tk1), 1);
            end
            if (n == 575) begin
                chk("s2 resume col+1", 32'(c1), 1);
                chk("s2 resume row", 32'(w1), 0);
            end
        end

        chk("std hsync low clocks", 32'(std_hs_lo), 192);
        chk("std video_on clocks", 32'(std_on), 1280);
        chk("std no vblank", 32'(std_vb), 0);
        chk("s2 hsync low clocks", 32'(s2_hs_lo), 60);
        chk("s2 vsync low clocks", 32'(s2_vs_lo), 60);
        chk("s2 video_on clocks", 32'(s2_on), 96);
        chk("s2 vblank count", 32'(s2_vb), 1);
        chk("s1 hsync low clocks", 32'(s1_hs_lo), 30);
        chk("s1 vsync low clocks", 32'(s1_vs_lo), 30);
        chk("s1 tick clocks", 32'(s1_tick), 150);
        chk("s1 vblank count", 32'(s1_vb), 1);
        chk("sp hsync high clocks", 32'(sp_hs_hi), 60);
        chk("sp vsync high clocks", 32'(sp_vs_hi), 60);
        chk("sp vblank count", 32'(sp_vb), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
